// File: rtl/fifo32x8_ctrl.sv
// fifo32x8_ctrl: 32-entry x 8-bit FIFO controller for a single-port 32x8 RAM.
// Owns pointers, occupancy and flags, and arbitrates between writer and reader.
// Each cycle is one RAM phase (IDLE, WRITE or READ), so the RAM is never double-booked.
module fifo32x8_ctrl (
  input  logic       Clock,
  input  logic       Reset_N,
  input  logic       Wr_Valid,
  input  logic [7:0] Wr_Data,
  output logic       Wr_Ready,
  input  logic       Rd_Req,
  output logic       Rd_Ready,
  output logic [7:0] Rd_Data,
  output logic       Rd_Valid,
  output logic       Full,
  output logic       Empty,
  output logic [5:0] Count,
  output logic [4:0] Ram_Address,
  output logic [7:0] Ram_Data,
  output logic       Ram_Write_Enable,
  output logic       Ram_Chip_Select,
  input  logic [7:0] Ram_Output
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} phase_e;
  typedef enum logic {GrantWrite, GrantRead} grant_e;

  phase_e      phase_q, phase_d;
  grant_e      last_grant_q, last_grant_d;
  logic [4:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]  rd_ptr_q, rd_ptr_d;
  logic [5:0]  count_q, count_d;
  logic [4:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        ram_we_q, ram_we_d;
  logic        ram_cs_q, ram_cs_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic full, empty;
  logic wr_elig, rd_elig;
  logic wr_acc, rd_acc;

  // Flags, eligibility and arbitration; under contention the side opposite last_grant wins.
  always_comb begin
    full     = (count_q == 6'd32);
    empty    = (count_q == 6'd0);
    wr_elig  = Wr_Valid & ~full;
    rd_elig  = Rd_Req & ~empty;
    Wr_Ready = ~full & ~(rd_elig & (last_grant_q == GrantWrite));
    Rd_Ready = ~empty & ~(wr_elig & (last_grant_q == GrantRead));
    wr_acc   = Wr_Valid & Wr_Ready;
    rd_acc   = Rd_Req & Rd_Ready;
  end

  // Next-state: phase selection, pointer/count update, RAM pin values and read capture.
  always_comb begin
    phase_d      = StIdle;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_we_d     = 1'b0;
    ram_cs_d     = 1'b0;
    // Data returned by the RAM during a READ phase is captured at the edge ending it.
    rd_valid_d   = (phase_q == StRead);
    rd_data_d    = (phase_q == StRead) ? Ram_Output : rd_data_q;

    if (wr_acc) begin
      phase_d      = StWrite;
      last_grant_d = GrantWrite;
      ram_addr_d   = wr_ptr_q;
      ram_data_d   = Wr_Data;
      ram_we_d     = 1'b1;
      ram_cs_d     = 1'b1;
      wr_ptr_d     = wr_ptr_q + 5'd1;
      count_d      = count_q + 6'd1;
    end else if (rd_acc) begin
      phase_d      = StRead;
      last_grant_d = GrantRead;
      ram_addr_d   = rd_ptr_q;
      ram_cs_d     = 1'b1;
      rd_ptr_d     = rd_ptr_q + 5'd1;
      count_d      = count_q - 6'd1;
    end
  end

  // State registers with synchronous active-low reset; reset aborts any in-flight phase.
  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      phase_q      <= StIdle;
      last_grant_q <= GrantRead;
      wr_ptr_q     <= 5'd0;
      rd_ptr_q     <= 5'd0;
      count_q      <= 6'd0;
      ram_addr_q   <= 5'd0;
      ram_data_q   <= 8'h00;
      ram_we_q     <= 1'b0;
      ram_cs_q     <= 1'b0;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_we_q     <= ram_we_d;
      ram_cs_q     <= ram_cs_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign Full             = full;
  assign Empty            = empty;
  assign Count            = count_q;
  assign Rd_Data          = rd_data_q;
  assign Rd_Valid         = rd_valid_q;
  assign Ram_Address      = ram_addr_q;
  assign Ram_Data         = ram_data_q;
  assign Ram_Write_Enable = ram_we_q;
  assign Ram_Chip_Select  = ram_cs_q;

endmodule

// File: tb/tb_fifo32x8_ctrl.sv
// Testbench for fifo32x8_ctrl: queue-based reference model plus a scoreboard monitor.
module tb_fifo32x8_ctrl;

  logic       Clock = 1'b0;
  logic       Reset_N;
  logic       Wr_Valid;
  logic [7:0] Wr_Data;
  logic       Wr_Ready;
  logic       Rd_Req;
  logic       Rd_Ready;
  logic [7:0] Rd_Data;
  logic       Rd_Valid;
  logic       Full;
  logic       Empty;
  logic [5:0] Count;
  logic [4:0] Ram_Address;
  logic [7:0] Ram_Data;
  logic       Ram_Write_Enable;
  logic       Ram_Chip_Select;
  logic [7:0] ram_out;

  always #5 Clock = ~Clock;

  fifo32x8_ctrl dut (
    .Clock            (Clock),
    .Reset_N          (Reset_N),
    .Wr_Valid         (Wr_Valid),
    .Wr_Data          (Wr_Data),
    .Wr_Ready         (Wr_Ready),
    .Rd_Req           (Rd_Req),
    .Rd_Ready         (Rd_Ready),
    .Rd_Data          (Rd_Data),
    .Rd_Valid         (Rd_Valid),
    .Full             (Full),
    .Empty            (Empty),
    .Count            (Count),
    .Ram_Address      (Ram_Address),
    .Ram_Data         (Ram_Data),
    .Ram_Write_Enable (Ram_Write_Enable),
    .Ram_Chip_Select  (Ram_Chip_Select),
    .Ram_Output       (ram_out)
  );

  // Behavioural 32x8 RAM: write at the edge ending a WRITE phase, combinational read.
  logic [7:0] mem [32];
  always @(posedge Clock) if (Ram_Chip_Select && Ram_Write_Enable) mem[Ram_Address] <= Ram_Data;
  assign ram_out = (Ram_Chip_Select && !Ram_Write_Enable) ? mem[Ram_Address] : 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run_en = 1'b0;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state (reset values).
  logic [7:0] q[$];
  int         m_wptr = 0;
  int         m_rptr = 0;
  bit         m_last_read = 1'b1;
  bit         exp_cs = 1'b0;
  bit         exp_we = 1'b0;
  logic [4:0] exp_addr = 5'd0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] exp_rd = 8'h00;

  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_t;
  sb_t sb[$];

  int  n;
  bit  w_rdy, r_rdy, wa, ra;
  sb_t e;

  // Model: check state and ready outputs, then advance the queue model by one edge.
  always @(negedge Clock) begin
    if (run_en) begin
      n = q.size();
      chk("count", 32'(Count), n);
      chk("full", 32'(Full), 32'(n == 32));
      chk("empty", 32'(Empty), 32'(n == 0));
      chk("ram_cs", 32'(Ram_Chip_Select), 32'(exp_cs));
      chk("ram_we", 32'(Ram_Write_Enable), 32'(exp_we));
      chk("ram_addr", 32'(Ram_Address), 32'(exp_addr));
      chk("ram_data", 32'(Ram_Data), 32'(exp_data));
      w_rdy = (n < 32) && !(Rd_Req && n > 0 && !m_last_read);
      r_rdy = (n > 0) && !(Wr_Valid && n < 32 && m_last_read);
      chk("wr_ready", 32'(Wr_Ready), 32'(w_rdy));
      chk("rd_ready", 32'(Rd_Ready), 32'(r_rdy));
      if (!Reset_N) begin
        q.delete();
        m_wptr = 0;
        m_rptr = 0;
        m_last_read = 1'b1;
        exp_cs = 1'b0;
        exp_we = 1'b0;
        exp_addr = 5'd0;
        exp_data = 8'h00;
        while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
      end else begin
        wa = Wr_Valid && w_rdy;
        ra = Rd_Req && r_rdy;
        exp_cs = wa || ra;
        exp_we = wa;
        if (wa) begin
          q.push_back(Wr_Data);
          exp_addr = 5'(m_wptr);
          exp_data = Wr_Data;
          m_wptr = (m_wptr + 1) % 32;
          m_last_read = 1'b0;
        end
        if (ra) begin
          e.data = q.pop_front();
          e.due = cyc + 2;
          sb.push_back(e);
          exp_addr = 5'(m_rptr);
          m_rptr = (m_rptr + 1) % 32;
          m_last_read = 1'b1;
        end
      end
    end
  end

  bit expv;
  // Monitor: pop the scoreboard when a read result is due and compare Rd_Valid/Rd_Data.
  always @(negedge Clock) begin
    if (run_en) begin
      expv = (sb.size() > 0) && (sb[0].due == cyc);
      chk("rd_valid", 32'(Rd_Valid), 32'(expv));
      if (expv) exp_rd = sb.pop_front().data;
      chk("rd_data", 32'(Rd_Data), 32'(exp_rd));
      if (!Reset_N) exp_rd = 8'h00;
    end
  end

  task automatic drive(input bit wv, input logic [7:0] wd, input bit rr);
    Wr_Valid = wv;
    Wr_Data  = wd;
    Rd_Req   = rr;
    @(posedge Clock);
    #1;
  endtask

  int wp, rp;

  initial begin
    Reset_N  = 1'b0;
    Wr_Valid = 1'b0;
    Wr_Data  = 8'h00;
    Rd_Req   = 1'b0;
    repeat (2) @(posedge Clock);
    #1 run_en = 1'b1;
    @(posedge Clock);
    #1 Reset_N = 1'b1;

    // Four writes then four reads.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h11 + i), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("empty_after_drain", 32'(Empty), 32'd1);

    // Fill to 32, hold a 33rd write, then drain with wrap.
    for (int i = 0; i < 32; i++) drive(1'b1, 8'(i * 3), 1'b0);
    chk("full_at_32", 32'(Full), 32'd1);
    repeat (5) drive(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 32; i++) drive(1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    // Read requests on an empty FIFO.
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Preload to 4 with a read last, then sustained contention.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      Wr_Valid = 1'b1;
      Wr_Data  = 8'(8'h80 + i);
      Rd_Req   = 1'b1;
      #1;
      chk("contention_wr_grant", 32'(Wr_Ready), 32'((i % 2) == 0));
      @(posedge Clock);
      #1;
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("count_after_contention", 32'(Count), 32'd4);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    // Write into empty, read at the next edge.
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("rd_data_a5", 32'(Rd_Data), 32'hA5);

    // Reset during a WRITE phase.
    drive(1'b1, 8'h5A, 1'b0);
    Reset_N = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("rst_cs", 32'(Ram_Chip_Select), 32'd0);
    chk("rst_we", 32'(Ram_Write_Enable), 32'd0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_rd_valid", 32'(Rd_Valid), 32'd0);
    Reset_N = 1'b1;
    drive(1'b0, 8'h00, 1'b0);

    // Randomized traffic with shifting write/read bias and rare resets.
    for (int blk = 0; blk < 30; blk++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        Reset_N = ($urandom_range(0, 399) != 0);
        drive($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
      end
    end
    Reset_N = 1'b1;
    repeat (5) drive(1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
